// File: rtl/block_exp_detect_if.sv
// Sample-pair bus for the block exponent detector: frame control and samples in,
// shift amount and status out.
interface block_exp_detect_if #(
  parameter int bw_in = 20
);
  logic                    Start;
  logic                    In_Valid;
  logic signed [bw_in-1:0] IN1;
  logic signed [bw_in-1:0] IN2;
  logic [3:0]              Amount;
  logic                    Busy;
  logic                    End;

  modport master (output Start, In_Valid, IN1, IN2, input Amount, Busy, End);
  modport slave  (input Start, In_Valid, IN1, IN2, output Amount, Busy, End);
endinterface

// File: rtl/block_exp_detect.sv
// Block floating-point exponent detector: ORs the magnitude bits of every sample in a
// frame and derives the common right shift that fits all samples into bw_out bits.
module block_exp_detect #(
  parameter int bw_in     = 20,
  parameter int bw_out    = 15,
  parameter int frame_len = 512,
  parameter int bw_cnt    = 9
) (
  input logic                Clock,
  input logic                Reset,
  block_exp_detect_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CALC = 2'd2
  } state_t;

  localparam logic [bw_cnt-1:0] CNT_LAST = bw_cnt'(frame_len - 1);

  state_t            state_q, state_d;
  logic [bw_in-2:0]  mask_q, mask_d;
  logic [bw_cnt-1:0] count_q, count_d;
  logic [3:0]        amount_q, amount_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;

  // Sign-folded magnitude bits: the top set bit marks the significant width minus two.
  function automatic logic [bw_in-2:0] fold_sample(input logic [bw_in-1:0] x);
    logic [bw_in-1:0] r;
    r = x ^ {bw_in{x[bw_in-1]}};
    return r[bw_in-2:0];
  endfunction

  function automatic logic [3:0] shift_amount(input logic [bw_in-2:0] m);
    logic [7:0] w;
    logic [7:0] diff;
    logic [3:0] amt;
    w = 8'd1;
    for (int i = 0; i < bw_in - 1; i++) begin
      if (m[i]) begin
        w = 8'(i + 2);
      end else begin
        w = w;
      end
    end
    diff = w - 8'(bw_out);
    if (w > 8'(bw_out)) begin
      amt = (diff > 8'd15) ? 4'd15 : diff[3:0];
    end else begin
      amt = 4'd0;
    end
    return amt;
  endfunction

  // Next-state, accumulator and result logic; Start overrides every state.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    count_d  = count_q;
    amount_d = amount_q;
    end_d    = 1'b0;
    if (bus.Start) begin
      state_d = ST_ACC;
      mask_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACC: begin
          if (bus.In_Valid) begin
            mask_d = mask_q | fold_sample(bus.IN1) | fold_sample(bus.IN2);
            if (count_q == CNT_LAST) begin
              count_d = '0;
              state_d = ST_CALC;
            end else begin
              count_d = count_q + {{(bw_cnt-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_CALC: begin
          amount_d = shift_amount(mask_q);
          end_d    = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      count_q  <= '0;
      amount_q <= 4'd0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      amount_q <= amount_d;
      end_q    <= end_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.Amount = amount_q;
  assign bus.End    = end_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_block_exp_detect.sv
// Directed, table-driven bench for block_exp_detect with frame_len=4.
module tb_block_exp_detect;

  localparam int BW_IN = 20;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   end_cnt;

  block_exp_detect_if #(.bw_in(BW_IN)) bus ();

  block_exp_detect #(
    .bw_in(BW_IN), .bw_out(15), .frame_len(4), .bw_cnt(2)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts End pulses one time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.End === 1'b1) end_cnt++;
  end

  typedef logic [3:0][BW_IN-1:0] quad_t;

  typedef struct {
    string      name;
    quad_t      in1;
    quad_t      in2;
    int         gap;
    logic [3:0] exp_amt;
  } vec_t;

  vec_t vecs[10];

  function automatic quad_t q4(input int a, input int b, input int c, input int d);
    quad_t q;
    q[0] = BW_IN'(a);
    q[1] = BW_IN'(b);
    q[2] = BW_IN'(c);
    q[3] = BW_IN'(d);
    return q;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic feed(input quad_t a, input quad_t b, input int gap);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        bus.In_Valid = 1'b0;
        @(negedge clk);
      end
      bus.In_Valid = 1'b1;
      bus.IN1 = a[i];
      bus.IN2 = b[i];
      @(negedge clk);
    end
    bus.In_Valid = 1'b0;
    bus.IN1 = '0;
    bus.IN2 = '0;
  endtask

  // Called at the negedge following the last accepted sample (CALC cycle).
  task automatic finish_check(input string nm, input logic [3:0] exp, input int e0);
    check({nm, "_calc_end"}, bus.End, 1'b0);
    check({nm, "_calc_busy"}, bus.Busy, 1'b1);
    @(negedge clk);
    check({nm, "_end"}, bus.End, 1'b1);
    check({nm, "_busy_low"}, bus.Busy, 1'b0);
    check({nm, "_amount"}, bus.Amount, exp);
    check({nm, "_one_end"}, end_cnt, e0 + 1);
    @(negedge clk);
    check({nm, "_end_drop"}, bus.End, 1'b0);
    check({nm, "_amount_hold"}, bus.Amount, exp);
  endtask

  task automatic start_pulse();
    int e0;
    bus.Start = 1'b1;
    bus.In_Valid = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic run_frame(input string nm, input quad_t a, input quad_t b, input int gap,
                           input logic [3:0] exp);
    int e0;
    start_pulse();
    check({nm, "_busy_start"}, bus.Busy, 1'b1);
    e0 = end_cnt;
    feed(a, b, gap);
    finish_check(nm, exp, e0);
  endtask

  initial begin
    int e0;
    n_checks = 0;
    n_fail   = 0;
    end_cnt  = 0;
    rst_n        = 1'b0;
    bus.Start    = 1'b0;
    bus.In_Valid = 1'b0;
    bus.IN1      = '0;
    bus.IN2      = '0;

    vecs[0] = '{"fit15",     q4(16383, -16384, 0, 5), q4(0, 0, 0, 0), 0, 4'd0};
    vecs[1] = '{"in2_16384", q4(0, 0, 0, 0), q4(0, 16384, 0, 0), 0, 4'd1};
    vecs[2] = '{"in1_m16385", q4(0, 0, -16385, 0), q4(0, 0, 0, 0), 0, 4'd1};
    vecs[3] = '{"in1_m16384", q4(0, -16384, 0, 0), q4(0, 0, 0, 0), 0, 4'd0};
    vecs[4] = '{"max_pos",   q4(0, 524287, 0, 0), q4(0, 0, 0, 0), 0, 4'd5};
    vecs[5] = '{"zeros",     q4(0, 0, 0, 0), q4(0, 0, 0, 0), 0, 4'd0};
    vecs[6] = '{"in2_65536", q4(7, 0, 0, 0), q4(0, 0, 65536, 0), 0, 4'd3};
    vecs[7] = '{"gap_max",   q4(0, 524287, 0, 0), q4(0, 0, 0, 0), 2, 4'd5};
    vecs[8] = '{"gap_fit15", q4(16383, -16384, 0, 5), q4(0, 0, 0, 0), 2, 4'd0};
    vecs[9] = '{"min_neg",   q4(0, 0, 0, 3), q4(-524288, 0, 0, 0), 0, 4'd5};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_amount", bus.Amount, 4'd0);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_end", bus.End, 1'b0);

    // Valid samples while idle must be ignored.
    e0 = end_cnt;
    bus.IN1 = BW_IN'(524287);
    repeat (6) begin
      bus.In_Valid = 1'b1;
      @(negedge clk);
    end
    bus.In_Valid = 1'b0;
    bus.IN1 = '0;
    @(negedge clk);
    check("idle_amount", bus.Amount, 4'd0);
    check("idle_busy", bus.Busy, 1'b0);
    check("idle_no_end", end_cnt, e0);

    for (int k = 0; k < 10; k++) begin
      run_frame(vecs[k].name, vecs[k].in1, vecs[k].in2, vecs[k].gap, vecs[k].exp_amt);
    end

    // Abort: restart after two large samples; the restart cycle's sample is dropped.
    run_frame("pre_abort", q4(524287, 0, 0, 0), q4(0, 0, 0, 0), 0, 4'd5);
    start_pulse();
    e0 = end_cnt;
    repeat (2) begin
      bus.In_Valid = 1'b1;
      bus.IN1 = BW_IN'(524287);
      @(negedge clk);
    end
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.In_Valid = 1'b0;
    bus.IN1 = '0;
    check("abort_no_end", end_cnt, e0);
    feed(q4(100, -100, 37, 0), q4(-1, 99, 0, 100), 0);
    finish_check("abort", 4'd0, e0);

    // Start during CALC: no End, Amount holds.
    run_frame("pre_calc_abort", q4(0, 0, 16384, 0), q4(0, 0, 0, 0), 0, 4'd1);
    start_pulse();
    e0 = end_cnt;
    feed(q4(524287, 0, 0, 0), q4(0, 0, 0, 0), 0);
    check("calc_abort_in_calc", bus.Busy, 1'b1);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    check("calc_abort_end", bus.End, 1'b0);
    check("calc_abort_amount", bus.Amount, 4'd1);
    check("calc_abort_busy", bus.Busy, 1'b1);
    @(negedge clk);
    check("calc_abort_end2", bus.End, 1'b0);
    check("calc_abort_cnt", end_cnt, e0);
    feed(q4(0, 0, 0, 0), q4(0, 0, 0, 0), 0);
    finish_check("after_calc_abort", 4'd0, e0);

    // Asynchronous reset mid-frame.
    run_frame("pre_reset", q4(0, 524287, 0, 0), q4(0, 0, 0, 0), 0, 4'd5);
    start_pulse();
    bus.In_Valid = 1'b1;
    bus.IN1 = BW_IN'(524287);
    repeat (2) @(negedge clk);
    bus.In_Valid = 1'b0;
    bus.IN1 = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_amount", bus.Amount, 4'd0);
    check("mid_rst_busy", bus.Busy, 1'b0);
    check("mid_rst_end", bus.End, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("post_reset", q4(0, 0, 0, 0), q4(16384, 0, 0, 0), 0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
